// File: rtl/step_pulse_gen.sv
// Single-cycle step strobe from the prescaled slow clock (auto) or a debounced button (manual).
// Define STEP_COUNTER_EN to build the wrapping step_count counter; otherwise step_count is 0.
module step_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   slow_clock,
    input  logic                   button,
    input  logic                   mode_manual,
    output logic                   step,
    output logic                   button_level,
    output logic [COUNT_WIDTH-1:0] step_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] slow_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic [SYNC_STAGES-1:0] vld_sync;

    logic          s_slow;
    logic          s_btn;
    logic          s_mode;
    logic          s_vld;
    logic          slow_hist;
    logic          slow_armed;
    logic          mode_q;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          mode_flip;
    logic          auto_fire;
    logic          press_fire;
    logic          step_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            slow_sync <= '0;
            btn_sync  <= '0;
            mode_sync <= '0;
            vld_sync  <= '0;
        end else begin
            slow_sync <= {slow_sync[SYNC_STAGES-2:0], slow_clock};
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], button};
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_manual};
            vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s_slow = slow_sync[SYNC_STAGES-1];
    assign s_btn  = btn_sync[SYNC_STAGES-1];
    assign s_mode = mode_sync[SYNC_STAGES-1];
    assign s_vld  = vld_sync[SYNC_STAGES-1];

    // The reset-cleared synchronizer fakes a 0->1 if slow_clock is already
    // high; only arm edge detection after a genuinely sampled low.
    assign auto_fire = !s_mode && slow_armed && s_slow && !slow_hist;

    assign mode_flip  = s_mode ^ mode_q;
    assign press_fire = s_mode && !mode_flip && (state == PRESS_WAIT)
                      && s_btn && (cnt == CNT_LAST);
    assign step_set   = (auto_fire || press_fire) && !step;

    always_ff @(posedge clock) begin
        if (reset) begin
            slow_hist    <= 1'b0;
            slow_armed   <= 1'b0;
            mode_q       <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            step         <= 1'b0;
            button_level <= 1'b0;
        end else begin
            slow_hist <= s_slow;
            mode_q    <= s_mode;
            step      <= step_set;
            if (s_vld && !s_slow) begin
                slow_armed <= 1'b1;
            end
            if (!s_mode || mode_flip) begin
                state        <= IDLE;
                cnt          <= '0;
                button_level <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (s_btn) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s_btn) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state        <= HELD;
                            cnt          <= '0;
                            button_level <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s_btn) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s_btn) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            button_level <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef STEP_COUNTER_EN
    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (step_set) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign step_count = count_q;
`else
    assign step_count = '0;
`endif

endmodule
